// File: rtl/instr_fetch_if.sv
// Instruction-memory read port between the fetch unit (master) and memory (slave).
// imem_rdata is valid in the same cycle that imem_ack accepts the request.
interface instr_fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/instr_fetch.sv
// Multi-cycle instruction fetch unit: fetches into IR, holds it during execution,
// then selects the next pc (jump > branch > sequential). A misaligned target locks up in FAULT.
//
// state   | meaning
// FETCH   | imem_req high at pc, waiting for imem_ack
// EXEC    | IR valid, waiting for exec_done to pick the next pc
// FAULT   | misaligned target seen, everything frozen until rst
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic               clk,
    input  logic               rst,
    instr_fetch_if.master      imem,
    output logic [31:0]        instr_o,
    output logic [5:0]         OpCode_o,
    output logic [5:0]         Funct_o,
    output logic               instr_valid_o,
    input  logic [1:0]         jump_i,
    input  logic [1:0]         Branch_i,
    input  logic               Zero_i,
    input  logic [31:0]        rs_data_i,
    input  logic               exec_done_i,
    output logic [31:0]        pc_o,
    output logic [31:0]        pc_plus4_o,
    output logic [31:0]        retired_o,
    output logic               fault_o
);

    typedef enum logic [1:0] {
        S_FETCH = 2'b00,
        S_EXEC  = 2'b01,
        S_FAULT = 2'b10
    } state_e;

    state_e      state_q;
    logic [31:0] pc_q;
    logic [31:0] ir_q;
    logic [31:0] retired_q;
    logic        fault_q;
    logic        req_q;
    logic        valid_q;

    logic [31:0] pc_plus4;
    logic [31:0] jump_tgt;
    logic [31:0] branch_tgt;
    logic        branch_taken;
    logic [31:0] target_d;

    assign pc_plus4     = pc_q + 32'd4;
    assign jump_tgt     = {pc_plus4[31:28], ir_q[25:0], 2'b00};
    assign branch_tgt   = pc_plus4 + {{14{ir_q[15]}}, ir_q[15:0], 2'b00};
    assign branch_taken = ((Branch_i == 2'b01) && Zero_i) ||
                          ((Branch_i == 2'b10) && !Zero_i);

    // Branch code 11 never counts as taken, so jump-class with jump=00 falls to pc+4.
    always_comb begin
        target_d = pc_plus4;
        case (jump_i)
            2'b01, 2'b10: target_d = jump_tgt;
            2'b11:        target_d = rs_data_i;
            default: begin
                if (branch_taken) begin
                    target_d = branch_tgt;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_FETCH;
            pc_q      <= RESET_PC;
            ir_q      <= 32'd0;
            retired_q <= 32'd0;
            fault_q   <= 1'b0;
            req_q     <= 1'b1;
            valid_q   <= 1'b0;
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (imem.imem_ack) begin
                        ir_q    <= imem.imem_rdata;
                        req_q   <= 1'b0;
                        valid_q <= 1'b1;
                        state_q <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (exec_done_i) begin
                        valid_q <= 1'b0;
                        if (target_d[1:0] != 2'b00) begin
                            fault_q <= 1'b1;
                            state_q <= S_FAULT;
                        end else begin
                            pc_q      <= target_d;
                            retired_q <= retired_q + 32'd1;
                            req_q     <= 1'b1;
                            state_q   <= S_FETCH;
                        end
                    end
                end
                S_FAULT: begin
                    state_q <= S_FAULT;
                end
                default: begin
                    req_q   <= 1'b0;
                    valid_q <= 1'b0;
                    fault_q <= 1'b1;
                    state_q <= S_FAULT;
                end
            endcase
        end
    end

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = pc_q;
    assign instr_o        = ir_q;
    assign OpCode_o       = ir_q[31:26];
    assign Funct_o        = ir_q[5:0];
    assign instr_valid_o  = valid_q;
    assign pc_o           = pc_q;
    assign pc_plus4_o     = pc_plus4;
    assign retired_o      = retired_q;
    assign fault_o        = fault_q;

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_3000, address of the first instruction fetched after reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 imem_req  output  1  instruction-memory read request.
REQ-005 imem_addr  output  32  fetch address, equal to pc while imem_req=1.
REQ-006 imem_ack  input  1  memory accepts the request; imem_rdata valid in the same cycle.
REQ-007 imem_rdata  input  32  fetched instruction word.
REQ-008 instr  output  32  instruction register (IR) contents.
REQ-009 OpCode  output  6  IR[31:26], drives the control decoder.
REQ-010 Funct  output  6  IR[5:0], drives the control decoder.
REQ-011 instr_valid  output  1  IR holds an instruction under execution.
REQ-012 jump  input  2  decoder jump code: 00 seq, 01 J, 10 JAL, 11 JR.
REQ-013 Branch  input  2  decoder branch code: 00 none, 01 BEQ, 10 BNE, 11 jump-class (no branch).
REQ-014 Zero  input  1  ALU equality flag for the current instruction.
REQ-015 rs_data  input  32  register rs value, JR target.
REQ-016 exec_done  input  1  single-cycle pulse: datapath finished the instruction; jump/Branch/Zero/rs_data valid this cycle.
REQ-017 pc  output  32  address of the instruction in IR / being fetched.
REQ-018 pc_plus4  output  32  pc+4 modulo 2^32, JAL link value.
REQ-019 retired  output  32  count of completed instructions.
REQ-020 fault  output  1  sticky misaligned-target error.

Function
REQ-021 FSM states FETCH, EXEC, FAULT; the FSM SHALL be encoded in a 2-bit state register.
REQ-022 FETCH: imem_req=1, imem_addr=pc held stable until imem_ack; on imem_ack, IR<=imem_rdata and FSM->EXEC next cycle.
REQ-023 An imem_ack in the first cycle of imem_req SHALL be accepted (zero-wait memory gives 1-cycle fetch).
REQ-024 EXEC: imem_req=0, instr_valid=1, IR and pc held until exec_done=1.
REQ-025 On exec_done in EXEC, next pc SHALL be selected with jump taking priority over Branch: jump 01/10 -> {pc_plus4[31:28], IR[25:0], 2'b00}; jump 11 -> rs_data; Branch 01 with Zero=1 or Branch 10 with Zero=0 -> pc_plus4 + (signext(IR[15:0])<<2) modulo 2^32; else pc_plus4.
REQ-026 Branch=11 with jump=00 SHALL be treated as sequential.
REQ-027 On exec_done with a selected target whose bits [1:0]!=00, the FSM SHALL go to FAULT, set fault=1, leave pc unchanged, and not increment retired.
REQ-028 Otherwise on exec_done: pc<=target, retired<=retired+1 (wraps at 2^32), FSM->FETCH next cycle.
REQ-029 FAULT: imem_req=0, instr_valid=0, all registers frozen; exit only through rst.
REQ-030 imem_ack outside FETCH and exec_done outside EXEC SHALL be ignored.
REQ-031 Minimum instruction period: 2 cycles (FETCH with immediate ack, EXEC with immediate exec_done).

Reset
REQ-032 While rst=1: pc=RESET_PC, IR=0, retired=0, fault=0, instr_valid=0, FSM=FETCH, imem_req=1 with imem_addr=RESET_PC in the first cycle after rst deasserts.
REQ-033 rst asserted in any state, including mid-wait for imem_ack, SHALL abort the operation immediately; the pending ack is discarded.

Verification
REQ-034 Reset release, ack after 3 cycles with imem_rdata=32'h1000_0003 -> imem_addr=0x3000 stable all 4 cycles, then instr_valid=1, OpCode=6'h04.
REQ-035 BEQ 32'h1000_0003 at 0x3000, exec_done with Branch=01: Zero=1 -> pc=0x3010; Zero=0 -> pc=0x3004; retired increments by 1.
REQ-036 J 32'h0800_0C00 at 0x3004, jump=01, Branch=11 -> pc=0x3000, imem_req=1 next cycle.
REQ-037 JR, jump=11, rs_data=0x0000_3002 -> fault=1, FSM=FAULT, imem_req=0, pc and retired unchanged; rst -> pc=0x3000, fault=0.
REQ-038 BNE with imm=16'hFFFF at 0x3000, Zero=0 -> pc=0x3000; imem_ack pulsed during EXEC -> IR unchanged.
